// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Round-robin arbiter and transaction sequencer sharing one spi_master among
// NREQ requesters. Each requester owns one active-low slave chip-select. A
// transaction grants one requester, latches its command and write word, and
// drops its chip-select for CS_SETUP cycles. It then holds the master request
// until ack, keeps the chip-select low for CS_HOLD cycles, and pulses done
// (plus err on watchdog timeout). One idle GAP cycle follows before the next
// grant.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_wr_i     per-requester write request (level, held until done)
//   req_rd_i     per-requester read request (level, held until done)
//   req_wdata_i  write words, requester i at [32i+31:32i]
//   gnt_o        one-hot grant, high from grant through end of HOLD
//   done_o       one-cycle pulse to the granted requester at transaction end
//   err_o        one-cycle pulse alongside done_o when ended by timeout
//   rd_data_o    read word captured at m_ack_i, valid with done_o
//   cs_n_o       active-low chip-selects, at most one low
//   m_wr_req_o   spi_master write request
//   m_rd_req_o   spi_master read request
//   m_wr_data_o  spi_master write word, stable while a request is high
//   m_rd_data_i  spi_master read word
//   m_ack_i      spi_master one-cycle acknowledge
// -----------------------------------------------------------------------------
module spi_arbiter #(
  parameter int NREQ     = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_wr_i,
  input  logic [NREQ-1:0]      req_rd_i,
  input  logic [32*NREQ-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic [31:0]          rd_data_o,
  output logic [NREQ-1:0]      cs_n_o,
  output logic                 m_wr_req_o,
  output logic                 m_rd_req_o,
  output logic [31:0]          m_wr_data_o,
  input  logic [31:0]          m_rd_data_i,
  input  logic                 m_ack_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BUSY,
    HOLD,
    DONE,
    GAP
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [NREQ-1:0]   err_q;
  logic [NREQ-1:0]   cs_n_q;
  logic              m_wr_req_q;
  logic              m_rd_req_q;
  logic [31:0]       m_wr_data_q;
  logic [31:0]       rd_data_q;
  logic              wrFlag_q;
  logic              rdFlag_q;
  logic              timedOut_q;
  logic [15:0]       phaseCnt_q;
  logic [15:0]       busyCnt_q;

  logic [NREQ-1:0]   pending;
  logic              winValid;
  logic [IDX_W-1:0]  winIdx;
  logic [NREQ-1:0]   winOneHot;
  logic [31:0]       winData;
  int                cand;

  assign pending = req_wr_i | req_rd_i;

  // Round-robin search starting just after the last winner. The loop walks
  // the offsets from farthest to nearest so the last hit, which is the
  // nearest pending requester after ptr_q, is the one that sticks.
  always_comb begin
    winValid  = 1'b0;
    winIdx    = '0;
    winOneHot = '0;
    winData   = '0;
    cand      = 0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (pending[cand[IDX_W-1:0]]) begin
        winValid  = 1'b1;
        winIdx    = cand[IDX_W-1:0];
        winOneHot = '0;
        winOneHot[cand[IDX_W-1:0]] = 1'b1;
        winData   = req_wdata_i[cand*32 +: 32];
      end
    end
  end

  // Transaction sequencer. All outputs are registered here, so cs_n drops on
  // the same edge as the grant and the SETUP count starts immediately.
  // BUSY cycles are numbered from 1 in busyCnt_q. An ack takes precedence
  // over the timeout in the cycle where both could apply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NREQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cs_n_q      <= '1;
      m_wr_req_q  <= 1'b0;
      m_rd_req_q  <= 1'b0;
      m_wr_data_q <= '0;
      rd_data_q   <= '0;
      wrFlag_q    <= 1'b0;
      rdFlag_q    <= 1'b0;
      timedOut_q  <= 1'b0;
      phaseCnt_q  <= '0;
      busyCnt_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (winValid) begin
            gnt_q       <= winOneHot;
            cs_n_q      <= ~winOneHot;
            wrFlag_q    <= req_wr_i[winIdx];
            rdFlag_q    <= req_rd_i[winIdx];
            m_wr_data_q <= winData;
            ptr_q       <= winIdx;
            phaseCnt_q  <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (phaseCnt_q == SETUP_LAST) begin
            phaseCnt_q <= '0;
            m_wr_req_q <= wrFlag_q;
            m_rd_req_q <= rdFlag_q;
            busyCnt_q  <= 16'd1;
            state_q    <= BUSY;
          end else begin
            phaseCnt_q <= phaseCnt_q + 16'd1;
          end
        end
        BUSY: begin
          if (m_ack_i) begin
            if (rdFlag_q) begin
              rd_data_q <= m_rd_data_i;
            end
            m_wr_req_q <= 1'b0;
            m_rd_req_q <= 1'b0;
            state_q    <= HOLD;
          end else if (busyCnt_q >= TIMEOUT_C) begin
            m_wr_req_q <= 1'b0;
            m_rd_req_q <= 1'b0;
            timedOut_q <= 1'b1;
            state_q    <= HOLD;
          end else if (busyCnt_q != 16'hFFFF) begin
            busyCnt_q <= busyCnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (phaseCnt_q == HOLD_LAST) begin
            phaseCnt_q <= '0;
            cs_n_q     <= '1;
            gnt_q      <= '0;
            done_q     <= gnt_q;
            err_q      <= timedOut_q ? gnt_q : '0;
            state_q    <= DONE;
          end else begin
            phaseCnt_q <= phaseCnt_q + 16'd1;
          end
        end
        DONE: begin
          wrFlag_q   <= 1'b0;
          rdFlag_q   <= 1'b0;
          timedOut_q <= 1'b0;
          busyCnt_q  <= '0;
          state_q    <= GAP;
        end
        GAP: begin
          // Lets spi_master settle back to its idle state before a new grant.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cs_n_o      = cs_n_q;
  assign rd_data_o   = rd_data_q;
  assign m_wr_req_o  = m_wr_req_q;
  assign m_rd_req_o  = m_rd_req_q;
  assign m_wr_data_o = m_wr_data_q;

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one spi_master instance among NREQ requesters, each owning one slave chip-select.
- Per transaction: grants one requester, latches its command and write word, and drives the requester's active-low chip-select with setup and hold guard times.
- Holds the master's request until its ack, then returns the read word and a done strobe.
- A watchdog flags transactions the master never acknowledges.

Parameters:
NREQ, 4, number of requesters / chip-selects (2..8)
CS_SETUP, 2, clk cycles cs_n is low before the master request asserts (>=1)
CS_HOLD, 2, clk cycles cs_n stays low after m_ack (>=1)
TIMEOUT, 1024, max clk cycles in BUSY awaiting m_ack before abort (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_wr  in  NREQ  per-requester write request, level, held until done
req_rd  in  NREQ  per-requester read request, level, held until done
req_wdata  in  32*NREQ  write word, requester i at bits [32i+31:32i]
gnt  out  NREQ  one-hot, high from grant through end of HOLD
done  out  NREQ  one-cycle pulse to the granted requester at transaction end
err  out  NREQ  one-cycle pulse with done when ended by timeout
rd_data  out  32  read word captured at m_ack, valid with done
cs_n  out  NREQ  active-low chip-selects, at most one low
m_wr_req  out  1  to spi_master wr_req
m_rd_req  out  1  to spi_master rd_req
m_wr_data  out  32  to spi_master wr_data, stable while m_*_req high
m_rd_data  in  32  from spi_master rd_data
m_ack  in  1  from spi_master ack, one-cycle pulse

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - gnt, done, err, m_wr_req and m_rd_req go to 0.
  - cs_n goes to all ones.
  - rd_data and m_wr_data go to 0.
  - The RR pointer goes to NREQ-1, so requester 0 has first priority.
  - All counters are cleared.
- Pending(i) = req_wr[i] | req_rd[i].
- Arbitration (IDLE only): pick the first pending index searching from ptr+1 upward, modulo NREQ.
  - Winner k: set gnt[k], latch wr_k/rd_k flags, latch req_wdata[k] into m_wr_data, set ptr=k.
  - Transition to SETUP.
- FSM states:
  - IDLE: no pending request -> stay. Otherwise grant as above -> SETUP next cycle.
  - SETUP: cs_n[k]=0. Count CS_SETUP cycles -> BUSY.
  - BUSY:
    - m_wr_req = latched wr flag; m_rd_req = latched rd flag. Both may be 1 (full duplex). cs_n[k]=0.
    - m_ack=1 -> capture m_rd_data into rd_data (only if rd flag, else rd_data unchanged); drop m_*_req next cycle -> HOLD.
    - Timeout counter reaches TIMEOUT with no m_ack -> drop m_*_req, set timeout flag -> HOLD.
  - HOLD: cs_n[k]=0 for CS_HOLD cycles -> DONE.
  - DONE: one cycle.
    - cs_n all ones; done[k]=1; err[k]=timeout flag.
    - Clear gnt, flags and timeout counter -> GAP.
  - GAP: one idle cycle so spi_master clears its internal is_wr/is_rd and returns cnt to 0 -> IDLE.
- Latency, uncontended, from req assertion to first cycle of m_*_req high: 1 (grant) + CS_SETUP cycles.
- Minimum spacing between consecutive grants: 2 cycles (DONE + GAP).
- Requests are sampled only in IDLE.
  - Deasserting req after grant does not cancel; the transaction completes.
  - Requesters must drop req in the cycle after done, or be re-queued at lowest RR priority.
- Simultaneous requests resolve strictly RR; a requester re-asserting immediately cannot starve others.
- m_ack outside BUSY is ignored.
- m_ack in the same cycle the timeout expires counts as ack: err=0, data captured.
- A timeout does not reset spi_master; err informs the requester only.
- Timeout counter is 16 bits wide; it counts BUSY cycles from 1 and saturates.
- m_rd_data is sampled only on the m_ack cycle.

Test Plan:
- Single write, NREQ=4, defaults: req_wr[2]=1, wdata2=0xA5A5_1234; ack after 10 BUSY cycles -> cs_n=4'b1011 for 2+10+2 cycles, m_wr_req high 10 cycles with m_wr_data=0xA5A51234, done[2] pulse, err=0.
- Read: req_rd[0]; m_rd_data=0xCAFEF00D at ack -> rd_data=0xCAFEF00D with done[0]; m_wr_req stays 0.
- Contention: req_wr=4'b1111 held continuously -> grant order 0,1,2,3,0; never two gnt bits set; ≥2 cycles between done and next gnt.
- Timeout: TIMEOUT=16, never ack -> m_wr_req drops after 16 BUSY cycles; done[k] and err[k] pulse together; rd_data unchanged.
- Ack/timeout coincidence: m_ack on the 16th BUSY cycle -> err=0, data captured.
- Reset mid-BUSY: rst_n low -> same cycle cs_n=all ones, m_*_req=0, gnt=0; after release, requester 0 wins first.
